task_3_scanner: RTL and testbench
=================================

# task_3_scanner

Sequential stimulus-and-capture stage that sits directly upstream of the `task_3_gate` function block. It drives that block's inputs A, B, C and D through all 16 combinations in order. After a settle delay it samples the block's 8-bit output and builds the 16-entry truth table. It compares the result against the expected minterm mask and reports pass/fail, the first failing index and the error count.

## Interface
- `EXPECTED`, default 16'hFEE8: expected truth table. Bit n is f at index n = {D,C,B,A}, so the default is ∑(3,5,6,7,9,10,11,12,13,14,15).
- `SETTLE_CYCLES`, default 1: cycles the inputs are held before sampling. Legal range 1..15.
- Clocking: one clock. Reset is asynchronous and active-low.
- `i_CLK`  in  1  clock; all state updates on the rising edge.
- `i_RST_N`  in  1  asynchronous active-low reset.
- `i_START`  in  1  start request; sampled only in IDLE.
- `i_Y`  in  8  output of the function block. Bit 0 is the function value; bits 7:1 must be 0.
- `o_A`, `o_B`, `o_C`, `o_D`  out  1 each  registered drive to the function block inputs.
- `o_BUSY`  out  1  high in every state except IDLE.
- `o_DONE`  out  1  one-cycle pulse when a scan completes.
- `o_PASS`  out  1  result of the last completed scan; held until the next scan completes.
- `o_TABLE`  out  16  captured truth table.
- `o_ERR_CNT`  out  5  number of mismatching indices (0..16).
- `o_FAIL_IDX`  out  4  lowest mismatching index. 0 when `o_ERR_CNT` = 0.

## Operation
- Index register `idx[3:0]`. The drive outputs are {o_D,o_C,o_B,o_A} = idx.
- **FSM states:** IDLE, SETTLE, SAMPLE, DONE.
- **IDLE:** idx = 0. When `i_START` = 1, the block:
  - clears `o_TABLE`, `o_ERR_CNT` and `o_FAIL_IDX`;
  - loads the settle counter with `SETTLE_CYCLES`;
  - moves to SETTLE.
- **SETTLE:** the counter decrements each cycle. The state lasts exactly `SETTLE_CYCLES` cycles, then moves to SAMPLE.
- **SAMPLE** (one cycle):
  - `o_TABLE[idx]` <= `i_Y[0]`.
  - A mismatch is `i_Y[0]` != `EXPECTED[idx]`, or `i_Y[7:1]` != 0.
  - On a mismatch, `o_ERR_CNT` increments. If this is the first mismatch (count was 0), `o_FAIL_IDX` <= idx.
  - If idx = 15, go to DONE. Otherwise idx <= idx+1, reload the settle counter and go to SETTLE.
- **DONE** (one cycle):
  - `o_DONE` = 1.
  - `o_PASS` <= (error count after the final sample == 0).
  - idx <= 0; return to IDLE.
- `i_START` is ignored while `o_BUSY` = 1.
- A new scan may start in the cycle immediately after DONE.
- `o_TABLE`, `o_ERR_CNT` and `o_FAIL_IDX` update live during a scan. They are final when `o_DONE` pulses and hold until the next start.
- **Arithmetic:** `o_ERR_CNT` is 5 bits wide and saturates naturally at 16, so it never wraps. idx wraps 15 -> 0 only via DONE.

## Timing
- **Reset values** (asynchronous, while `i_RST_N` = 0):
  - state = IDLE, idx = 0;
  - all drive outputs 0;
  - `o_BUSY`, `o_DONE` and `o_PASS` = 0;
  - `o_TABLE` = 16'h0000, `o_ERR_CNT` = 0, `o_FAIL_IDX` = 0.
- **Start:** if `i_START` is sampled high at edge k (in IDLE), then `o_BUSY` = 1 from cycle k+1.
- **Per index:** idx is stable for `SETTLE_CYCLES` + 1 cycles, and `i_Y` is sampled on the last of them. The function block is combinational, so its output is valid one cycle after the drive changes.
- **Done:** `o_DONE` is high in cycle k+1+16·(`SETTLE_CYCLES`+1). With the default this is k+33. `o_BUSY` is still 1 in that cycle and returns to 0 at k+34.
- **Reset mid-scan:** the block returns immediately to the reset values. A partial table is discarded and no `o_DONE` is produced.
- **Start and reset together:** reset dominates.

## Test plan
- **Correct DUT**, default parameters, `i_START` pulsed at cycle 0:
  - {D,C,B,A} steps 0..15, with each value held for 2 cycles;
  - `o_DONE` at cycle 33;
  - `o_TABLE` = 16'hFEE8, `o_ERR_CNT` = 0, `o_PASS` = 1.
- **DUT with output stuck at 0:**
  - `o_TABLE` = 16'h0000, `o_ERR_CNT` = 11, `o_FAIL_IDX` = 3, `o_PASS` = 0.
- **Upper bits driven, `i_Y` = {7'b0000001, f}:**
  - `o_TABLE` = 16'hFEE8, `o_ERR_CNT` = 16, `o_FAIL_IDX` = 0, `o_PASS` = 0.
- **`SETTLE_CYCLES` = 3, correct DUT:**
  - each idx is held for 4 cycles;
  - `o_DONE` at cycle 65; `o_PASS` = 1.
- **Start re-pulsed mid-scan (idx = 5):** ignored. The scan completes on the original schedule (cycle 33), and exactly one `o_DONE` pulse is seen.
- **`i_RST_N` = 0 asserted while idx = 7:**
  - all outputs at reset values in the same cycle; no `o_DONE`.
  - A subsequent start gives a full, correct scan with `o_PASS` = 1.

Source files
------------

// File: rtl/task_3_scanner.sv
// task_3_scanner
// Stimulus-and-capture stage for the task_3_gate function block. It steps the
// block's inputs {D,C,B,A} through 0..15, waits SETTLE_CYCLES cycles at each
// index, samples the block's 8-bit output and builds a 16-entry truth table.
// The table is compared against EXPECTED, and the stage reports pass/fail, the
// lowest failing index and the number of failing indices.
//
// Parameters:
//   EXPECTED       expected truth table, bit n = f({D,C,B,A} = n)
//   SETTLE_CYCLES  cycles each index is held before sampling (1..15)
// Ports:
//   i_CLK       clock, rising edge
//   i_RST_N     asynchronous active-low reset
//   i_START     start request, honoured only in IDLE
//   i_Y[7:0]    function block output; bit 0 = f, bits 7:1 must be zero
//   o_A..o_D    registered drive to the function block ({D,C,B,A} = idx)
//   o_BUSY      high whenever not IDLE
//   o_DONE      one-cycle pulse when a scan completes
//   o_PASS      result of the last completed scan
//   o_TABLE     captured truth table (updates live during a scan)
//   o_ERR_CNT   number of mismatching indices (0..16)
//   o_FAIL_IDX  lowest mismatching index, 0 when there is none
module task_3_scanner #(
  parameter logic [15:0] EXPECTED      = 16'hFEE8,
  parameter int          SETTLE_CYCLES = 1
) (
  input  logic        i_CLK,
  input  logic        i_RST_N,
  input  logic        i_START,
  input  logic [7:0]  i_Y,
  output logic        o_A,
  output logic        o_B,
  output logic        o_C,
  output logic        o_D,
  output logic        o_BUSY,
  output logic        o_DONE,
  output logic        o_PASS,
  output logic [15:0] o_TABLE,
  output logic [4:0]  o_ERR_CNT,
  output logic [3:0]  o_FAIL_IDX
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_next;
  logic [3:0] idx;
  logic [3:0] settle_cnt;
  logic       mismatch;

  // Any nonzero upper bit is a fault of the block even if bit 0 is right.
  assign mismatch = (i_Y[0] != EXPECTED[idx]) || (i_Y[7:1] != 7'd0);

  assign o_A = idx[0];
  assign o_B = idx[1];
  assign o_C = idx[2];
  assign o_D = idx[3];

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_BUSY     = (state != IDLE);
    o_DONE     = 1'b0;
    case (state)
      IDLE: begin
        if (i_START) begin
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        // Counter is loaded with SETTLE_CYCLES, so leaving at 1 gives exactly
        // SETTLE_CYCLES cycles in this state.
        if (settle_cnt == 4'd1) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        state_next = (idx == 4'd15) ? DONE : SETTLE;
      end
      DONE: begin
        o_DONE     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      idx        <= 4'd0;
      settle_cnt <= 4'd0;
      o_TABLE    <= 16'h0000;
      o_ERR_CNT  <= 5'd0;
      o_FAIL_IDX <= 4'd0;
      o_PASS     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          idx <= 4'd0;
          if (i_START) begin
            o_TABLE    <= 16'h0000;
            o_ERR_CNT  <= 5'd0;
            o_FAIL_IDX <= 4'd0;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
        end
        SAMPLE: begin
          o_TABLE[idx] <= i_Y[0];
          if (mismatch) begin
            // At most 16 increments per scan, so 5 bits never wrap.
            o_ERR_CNT <= o_ERR_CNT + 5'd1;
            if (o_ERR_CNT == 5'd0) begin
              o_FAIL_IDX <= idx;
            end
          end
          if (idx != 4'd15) begin
            idx        <= idx + 4'd1;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        DONE: begin
          o_PASS <= (o_ERR_CNT == 5'd0);
          idx    <= 4'd0;
        end
        default: begin
          idx <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_task_3_scanner.sv
// Testbench for task_3_scanner: two instances (SETTLE_CYCLES = 1 and 3) are
// each driven by a behavioural function block whose per-index output is taken
// from a truth table and an "upper bits set" mask chosen by the test.
module tb_task_3_scanner;

  localparam logic [15:0] EXP_TT = 16'hFEE8;

  logic        clk;
  logic        rst_n;
  logic        start   [2];
  logic [7:0]  y       [2];
  logic        oa      [2];
  logic        ob      [2];
  logic        oc      [2];
  logic        od      [2];
  logic        busy    [2];
  logic        done    [2];
  logic        pass    [2];
  logic [15:0] tbl     [2];
  logic [4:0]  err     [2];
  logic [3:0]  fidx    [2];
  logic [3:0]  drv     [2];

  logic [15:0] cur_tt;
  logic [15:0] cur_up;
  logic [6:0]  cur_upval;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task_3_scanner #(.EXPECTED(EXP_TT), .SETTLE_CYCLES(1)) dut0 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start[0]), .i_Y(y[0]),
    .o_A(oa[0]), .o_B(ob[0]), .o_C(oc[0]), .o_D(od[0]),
    .o_BUSY(busy[0]), .o_DONE(done[0]), .o_PASS(pass[0]),
    .o_TABLE(tbl[0]), .o_ERR_CNT(err[0]), .o_FAIL_IDX(fidx[0])
  );

  task_3_scanner #(.EXPECTED(EXP_TT), .SETTLE_CYCLES(3)) dut1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_START(start[1]), .i_Y(y[1]),
    .o_A(oa[1]), .o_B(ob[1]), .o_C(oc[1]), .o_D(od[1]),
    .o_BUSY(busy[1]), .o_DONE(done[1]), .o_PASS(pass[1]),
    .o_TABLE(tbl[1]), .o_ERR_CNT(err[1]), .o_FAIL_IDX(fidx[1])
  );

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      drv[w] = {od[w], oc[w], ob[w], oa[w]};
    end
  end

  // Behavioural function block: combinational lookup on the drive lines.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      y[w] = 8'd0;
      y[w][0] = cur_tt[drv[w]];
      if (cur_up[drv[w]]) y[w][7:1] = cur_upval;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: score each index independently against the expected table.
  task automatic model(input logic [15:0] tt, input logic [15:0] up,
                       output logic [15:0] t, output int e, output int f,
                       output int p);
    e = 0;
    f = 0;
    for (int n = 0; n < 16; n++) begin
      if (tt[n] != EXP_TT[n] || up[n]) begin
        if (e == 0) f = n;
        e++;
      end
    end
    t = tt;
    p = (e == 0) ? 1 : 0;
  endtask

  task automatic run_scan(input int w, input int s, input string name,
                          input logic [15:0] e_tbl, input int e_err,
                          input int e_fidx, input int e_pass,
                          input int restart_idx);
    int  done_c;
    int  n_done;
    int  seq_bad;
    int  exp_idx;
    bit  restarted;
    int  busy_after;
    done_c     = -1;
    n_done     = 0;
    seq_bad    = 0;
    restarted  = 0;
    busy_after = -1;
    @(posedge clk); #1;
    start[w] = 1'b1;
    @(posedge clk); #1;   // edge k has sampled start
    start[w] = 1'b0;
    check({name, " busy_at_k1"}, busy[w], 1);
    check({name, " cleared_at_start"}, {tbl[w], err[w], fidx[w]}, 0);
    for (int c = 1; c <= 20 * (s + 1) + 4; c++) begin
      if (c <= 16 * (s + 1)) begin
        exp_idx = (c - 1) / (s + 1);
        if (int'(drv[w]) != exp_idx) seq_bad++;
      end
      if (start[w]) start[w] = 1'b0;
      if (restart_idx >= 0 && !restarted && int'(drv[w]) == restart_idx) begin
        start[w]  = 1'b1;
        restarted = 1;
      end
      if (done[w]) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (done_c > 0 && c == done_c + 1) busy_after = busy[w];
      @(posedge clk); #1;
    end
    start[w] = 1'b0;
    check({name, " drive_seq_bad_cycles"}, seq_bad, 0);
    check({name, " done_cycle"}, done_c, 1 + 16 * (s + 1));
    check({name, " done_pulses"}, n_done, 1);
    check({name, " busy_after_done"}, busy_after, 0);
    check({name, " table"}, tbl[w], e_tbl);
    check({name, " err_cnt"}, err[w], e_err);
    check({name, " fail_idx"}, fidx[w], e_fidx);
    check({name, " pass"}, pass[w], e_pass);
    $display("scan %s: table=%h err=%0d fidx=%0d pass=%0d done_at=%0d",
             name, tbl[w], err[w], fidx[w], pass[w], done_c);
  endtask

  typedef struct {
    string       name;
    logic [15:0] tt;
    logic [15:0] up;
    logic [15:0] e_tbl;
    int          e_err;
    int          e_fidx;
    int          e_pass;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [15:0] m_tbl;
    int          m_err;
    int          m_f;
    int          m_p;
    int          wait_c;
    int          rst_done;

    vecs[0] = '{"correct",    16'hFEE8, 16'h0000, 16'hFEE8,  0,  0, 1};
    vecs[1] = '{"stuck0",     16'h0000, 16'h0000, 16'h0000, 11,  3, 0};
    vecs[2] = '{"upper_all",  16'hFEE8, 16'hFFFF, 16'hFEE8, 16,  0, 0};
    vecs[3] = '{"stuck1",     16'hFFFF, 16'h0000, 16'hFFFF,  5,  0, 0};
    vecs[4] = '{"flip15",     16'h7EE8, 16'h0000, 16'h7EE8,  1, 15, 0};
    vecs[5] = '{"upper9",     16'hFEE8, 16'h0200, 16'hFEE8,  1,  9, 0};

    rst_n     = 1'b0;
    start[0]  = 1'b0;
    start[1]  = 1'b0;
    cur_tt    = EXP_TT;
    cur_up    = 16'h0000;
    cur_upval = 7'd1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs0",
          {drv[0], busy[0], done[0], pass[0], tbl[0], err[0], fidx[0]}, 0);
    check("reset_outputs1",
          {drv[1], busy[1], done[1], pass[1], tbl[1], err[1], fidx[1]}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      cur_tt    = vecs[i].tt;
      cur_up    = vecs[i].up;
      cur_upval = 7'd1;
      run_scan(0, 1, vecs[i].name, vecs[i].e_tbl, vecs[i].e_err,
               vecs[i].e_fidx, vecs[i].e_pass, -1);
    end

    // Longer settle time on the second instance
    cur_tt = EXP_TT;
    cur_up = 16'h0000;
    run_scan(1, 3, "settle3", 16'hFEE8, 0, 0, 1, -1);

    // Start re-pulsed mid-scan at idx 5 must be ignored
    run_scan(0, 1, "restart5", 16'hFEE8, 0, 0, 1, 5);

    // Randomized scans against the reference model
    for (int r = 0; r < 8; r++) begin
      cur_tt    = 16'($urandom);
      cur_up    = (r % 2 == 0) ? 16'h0000 : 16'($urandom & $urandom & $urandom);
      cur_upval = 7'($urandom_range(1, 127));
      model(cur_tt, cur_up, m_tbl, m_err, m_f, m_p);
      run_scan(r % 2, (r % 2 == 0) ? 1 : 3, $sformatf("rand%0d", r),
               m_tbl, m_err, m_f, m_p, -1);
    end

    // Reset asserted while idx = 7: immediate return to reset values
    cur_tt   = 16'h0000;
    cur_up   = 16'h0000;
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_c = 0;
    while (drv[0] != 4'd7 && wait_c < 100) begin
      @(posedge clk); #1;
      wait_c++;
    end
    check("reach_idx7", drv[0], 7);
    rst_n = 1'b0;
    #1;
    check("midscan_reset_outputs",
          {drv[0], busy[0], done[0], pass[0], tbl[0], err[0], fidx[0]}, 0);
    rst_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
      if (done[0]) rst_done++;
    end
    check("no_done_after_reset", rst_done, 0);
    cur_tt = EXP_TT;
    run_scan(0, 1, "after_reset", 16'hFEE8, 0, 0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
